conv_line_ctrl: RTL and testbench
=================================

Name: conv_line_ctrl

Overview:
Sequencer that feeds the conv kernel datapath from a raster pixel stream. It stores incoming lines in KERNEL_W+1 rotating line buffers. Once KERNEL_W lines are held, it emits one KERNEL_W x KERNEL_W window per cycle on the pixel_data/pixel_data_valid interface of conv. It back-pressures the source when all buffers are occupied and handles frame boundaries.

Parameters:
DATA_W, 8, pixel width in bits
KERNEL_W, 3, kernel/window edge size (>=2)
IMG_W, 512, pixels per line (>= KERNEL_W)
IMG_H, 512, lines per frame (>= KERNEL_W)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
pixel_i  in  DATA_W  input pixel, raster order
pixel_valid_i  in  1  pixel_i valid
pixel_ready_o  out  1  controller accepts pixel_i this cycle
pixel_data_o  out  [KERNEL_W-1:0][KERNEL_W-1:0] x DATA_W (unpacked)  window to conv
pixel_data_valid_o  out  1  pixel_data_o valid (one cycle per window)
frame_done_o  out  1  single-cycle pulse after the last window of a frame
busy_o  out  1  high from first accepted pixel of a frame until frame_done_o

Behaviour:
- Reset (async assert, sync release): pixel_ready_o=1; pixel_data_valid_o, frame_done_o and busy_o=0; pixel_data_o all zero. Counters and pointers clear. Any partially received frame is discarded.
- Write side:
  - A pixel is accepted when pixel_valid_i && pixel_ready_o.
  - It is written to buffer wbuf at column wcol, then wcol++.
  - At wcol==IMG_W-1: wcol<=0, wbuf<=(wbuf+1) mod (KERNEL_W+1), lines_full++, wrow++.
- pixel_ready_o = (lines_full < KERNEL_W+1) && (wrow < IMG_H). Source data is ignored while ready is low.
- Read FSM states: IDLE, READ, FLUSH.
  - IDLE -> READ when lines_full >= KERNEL_W.
  - READ: rcol runs 0..IMG_W-KERNEL_W, one step per cycle, with no stalls.
  - Window element [r][c] = buffer (rbuf+r) mod (KERNEL_W+1), column rcol+c. Row r=0 is the oldest line; column c=0 is the leftmost pixel.
  - Output is registered: pixel_data_o/pixel_data_valid_o appear 1 cycle after the READ cycle that addresses them.
  - At rcol==IMG_W-KERNEL_W: rcol<=0, rbuf++, lines_full--, orow++.
  - If orow reaches IMG_H-KERNEL_W+1, go to FLUSH; otherwise return to IDLE. This gives a mandatory one-cycle bubble between window rows.
  - FLUSH (1 cycle): lines_full, wbuf, rbuf, wrow, orow, wcol <= 0. The remaining KERNEL_W-1 lines are discarded. frame_done_o pulses, timed one cycle after the last pixel_data_valid_o. busy_o falls and the FSM goes to IDLE.
- Simultaneous write-line-complete and read-line-release in the same cycle: lines_full is unchanged (net +1-1).
- lines_full never exceeds KERNEL_W+1 and never underflows. The read side never addresses a buffer being written, because the write buffer is always outside the KERNEL_W read set.
- Next frame pixels are accepted only after FLUSH, via wrow reset.
- Windows per frame = (IMG_W-KERNEL_W+1)*(IMG_H-KERNEL_W+1).
- No multi-cycle arithmetic. Counter widths are $clog2 of their maximum+1. Buffers are register arrays, so all KERNEL_W columns of KERNEL_W lines are read combinationally in one cycle.

Test Plan:
(Configuration for all scenarios: KERNEL_W=3, IMG_W=8, IMG_H=6, DATA_W=8, pixel value = 8*row+col mod 256.)
1. Continuous valid, full frame.
   -> Exactly 24 windows arrive in 4 bursts of 6, each burst separated by a 1-cycle gap.
   -> The first window is {{0,1,2},{8,9,10},{16,17,18}}; the last is {{29,30,31},{37,38,39},{45,46,47}}.
   -> frame_done_o pulses once, 1 cycle after the last valid window.
2. Random valid gaps (50% duty).
   -> The same 24 windows arrive in the same order; no window is duplicated or dropped.
3. Back-pressure: stream continuously.
   -> pixel_ready_o drops whenever lines_full==4 and drops after pixel 47 until FLUSH.
   -> No accepted pixel is lost; window contents match scenario 1.
4. Two back-to-back frames, frame 2 values offset by +100.
   -> First window of frame 2 is {{100,101,102},{108,109,110},{116,117,118}}.
   -> frame_done_o pulses twice; busy_o goes low between the frames.
5. Assert rst_i asynchronously mid-frame (after 20 pixels).
   -> All outputs return to their reset values immediately.
   -> A fresh frame afterwards reproduces scenario 1 exactly.
6. Line-complete and row-release in the same cycle (force by timing).
   -> lines_full is unchanged; pixel_ready_o is unaffected; windows are correct.

Source files
------------

// File: rtl/conv_line_ctrl.sv
// Line-buffer sequencer for the conv kernel: stores raster lines in KERNEL_W+1 rotating
// buffers and streams one KERNEL_W x KERNEL_W window per cycle once enough lines are held.
module conv_line_ctrl #(
   parameter int DATA_W   = 8,
   parameter int KERNEL_W = 3,
   parameter int IMG_W    = 512,
   parameter int IMG_H    = 512
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] pixel_i,
   input  logic              pixel_valid_i,
   output logic              pixel_ready_o,
   output logic [DATA_W-1:0] pixel_data_o [KERNEL_W][KERNEL_W],
   output logic              pixel_data_valid_o,
   output logic              frame_done_o,
   output logic              busy_o
);

   localparam int NBUF   = KERNEL_W + 1;
   localparam int BUF_W  = $clog2(NBUF);
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H + 1);
   localparam int LF_W   = $clog2(NBUF + 1);
   localparam int RCOL_W = (IMG_W - KERNEL_W + 1 > 1) ? $clog2(IMG_W - KERNEL_W + 1) : 1;
   localparam int OROW_W = $clog2(IMG_H - KERNEL_W + 2);

   localparam logic [BUF_W-1:0]  BUF_LAST  = BUF_W'(NBUF - 1);
   localparam logic [BUF_W:0]    BUF_COUNT = (BUF_W + 1)'(NBUF);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(IMG_H);
   localparam logic [LF_W-1:0]   LF_FULL   = LF_W'(NBUF);
   localparam logic [LF_W-1:0]   LF_READY  = LF_W'(KERNEL_W);
   localparam logic [RCOL_W-1:0] RCOL_LAST = RCOL_W'(IMG_W - KERNEL_W);
   localparam logic [OROW_W-1:0] OROW_LAST = OROW_W'(IMG_H - KERNEL_W);

   typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

   logic [DATA_W-1:0] line_q [NBUF][IMG_W];
   logic [DATA_W-1:0] line_d [NBUF][IMG_W];

   state_t            state_q, state_d;
   logic [COL_W-1:0]  wcol_q, wcol_d;
   logic [BUF_W-1:0]  wbuf_q, wbuf_d;
   logic [ROW_W-1:0]  wrow_q, wrow_d;
   logic [LF_W-1:0]   lines_full_q, lines_full_d;
   logic [RCOL_W-1:0] rcol_q, rcol_d;
   logic [BUF_W-1:0]  rbuf_q, rbuf_d;
   logic [OROW_W-1:0] orow_q, orow_d;
   logic [DATA_W-1:0] pix_data_q [KERNEL_W][KERNEL_W];
   logic [DATA_W-1:0] pix_data_d [KERNEL_W][KERNEL_W];
   logic              pix_valid_q, pix_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;

   logic              accept;
   logic              line_done;
   logic              row_release;
   logic [BUF_W:0]    rb_sum;
   logic [COL_W-1:0]  col;

   assign pixel_ready_o = (lines_full_q < LF_FULL) && (wrow_q < ROW_END);
   assign accept        = pixel_valid_i && pixel_ready_o;
   assign line_done     = accept && (wcol_q == COL_LAST);
   assign row_release   = (state_q == READ) && (rcol_q == RCOL_LAST);

   always_comb begin
      line_d       = line_q;
      state_d      = state_q;
      wcol_d       = wcol_q;
      wbuf_d       = wbuf_q;
      wrow_d       = wrow_q;
      lines_full_d = lines_full_q;
      rcol_d       = rcol_q;
      rbuf_d       = rbuf_q;
      orow_d       = orow_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      rb_sum       = '0;
      col          = '0;

      if (accept) begin
         line_d[wbuf_q][wcol_q] = pixel_i;
         busy_d                 = 1'b1;
         if (line_done) begin
            wcol_d = '0;
            wbuf_d = (wbuf_q == BUF_LAST) ? '0 : wbuf_q + 1'b1;
            wrow_d = wrow_q + 1'b1;
         end else begin
            wcol_d = wcol_q + 1'b1;
         end
      end

      // A line landing in the same cycle a window row is retired leaves the count unchanged.
      case ({line_done, row_release})
         2'b10:   lines_full_d = lines_full_q + 1'b1;
         2'b01:   lines_full_d = lines_full_q - 1'b1;
         default: lines_full_d = lines_full_q;
      endcase

      case (state_q)
         IDLE: begin
            if (lines_full_q >= LF_READY) begin
               state_d = READ;
            end
         end
         READ: begin
            pix_valid_d = 1'b1;
            for (int r = 0; r < KERNEL_W; r++) begin
               for (int c = 0; c < KERNEL_W; c++) begin
                  rb_sum = {1'b0, rbuf_q} + (BUF_W + 1)'(r);
                  if (rb_sum > {1'b0, BUF_LAST}) begin
                     rb_sum = rb_sum - BUF_COUNT;
                  end
                  col = COL_W'(rcol_q) + COL_W'(c);
                  pix_data_d[r][c] = line_q[rb_sum[BUF_W-1:0]][col];
               end
            end
            if (row_release) begin
               rcol_d  = '0;
               rbuf_d  = (rbuf_q == BUF_LAST) ? '0 : rbuf_q + 1'b1;
               orow_d  = orow_q + 1'b1;
               state_d = (orow_q == OROW_LAST) ? FLUSH : IDLE;
            end else begin
               rcol_d = rcol_q + 1'b1;
            end
         end
         FLUSH: begin
            // The trailing KERNEL_W-1 lines never form a full window and are dropped here.
            lines_full_d = '0;
            wbuf_d       = '0;
            rbuf_d       = '0;
            wrow_d       = '0;
            orow_d       = '0;
            wcol_d       = '0;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      line_q <= line_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         wcol_q       <= '0;
         wbuf_q       <= '0;
         wrow_q       <= '0;
         lines_full_q <= '0;
         rcol_q       <= '0;
         rbuf_q       <= '0;
         orow_q       <= '0;
         for (int r = 0; r < KERNEL_W; r++) begin
            for (int c = 0; c < KERNEL_W; c++) begin
               pix_data_q[r][c] <= '0;
            end
         end
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcol_q       <= wcol_d;
         wbuf_q       <= wbuf_d;
         wrow_q       <= wrow_d;
         lines_full_q <= lines_full_d;
         rcol_q       <= rcol_d;
         rbuf_q       <= rbuf_d;
         orow_q       <= orow_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign pixel_data_o       = pix_data_q;
   assign pixel_data_valid_o = pix_valid_q;
   assign frame_done_o       = frame_done_q;
   assign busy_o             = busy_q;

endmodule

// File: tb/tb_conv_line_ctrl.sv
// Scoreboard bench for conv_line_ctrl on a small 8x6 image with a 3x3 window.
module tb_conv_line_ctrl;

   localparam int DW   = 8;
   localparam int K    = 3;
   localparam int IW   = 8;
   localparam int IH   = 6;
   localparam int WB   = K * K * DW;
   localparam int WPR  = IW - K + 1;
   localparam int WPF  = WPR * (IH - K + 1);
   localparam int NPIX = IW * IH;

   logic          clk_i;
   logic          rst_i;
   logic [DW-1:0] pixel_i;
   logic          pixel_valid_i;
   logic          pixel_ready_o;
   logic [DW-1:0] pixel_data_o [K][K];
   logic          pixel_data_valid_o;
   logic          frame_done_o;
   logic          busy_o;

   logic [WB-1:0] exp_q [$];
   int            check_cnt = 0;
   int            pass_cnt  = 0;
   int            fd_cnt    = 0;

   conv_line_ctrl #(
      .DATA_W  (DW),
      .KERNEL_W(K),
      .IMG_W   (IW),
      .IMG_H   (IH)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .pixel_i           (pixel_i),
      .pixel_valid_i     (pixel_valid_i),
      .pixel_ready_o     (pixel_ready_o),
      .pixel_data_o      (pixel_data_o),
      .pixel_data_valid_o(pixel_data_valid_o),
      .frame_done_o      (frame_done_o),
      .busy_o            (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      check_cnt++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic logic [WB-1:0] flatWin();
      logic [WB-1:0] f;
      f = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            f[(r*K+c)*DW +: DW] = pixel_data_o[r][c];
         end
      end
      return f;
   endfunction

   // Reference window: pixel value is offset + 8*row + col, row 0 oldest, col 0 leftmost.
   function automatic logic [WB-1:0] expWin(input int off, input int row, input int col);
      logic [WB-1:0] f;
      f = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            f[(r*K+c)*DW +: DW] = DW'((off + IW*(row+r) + col + c) & 255);
         end
      end
      return f;
   endfunction

   task automatic applyStimulus(input int off, input bit gaps, input int npix);
      int wait_cyc;
      for (int i = 0; i < npix; i++) begin
         wait_cyc = 0;
         forever begin
            @(negedge clk_i);
            if (gaps && $urandom_range(1) == 0) begin
               pixel_valid_i = 1'b0;
            end else begin
               pixel_valid_i = 1'b1;
               pixel_i       = DW'((off + i) & 255);
               if (pixel_ready_o) break;
            end
            wait_cyc++;
            if (wait_cyc > 400) begin
               checkOutput("ready_timeout", WB'(pixel_ready_o), WB'(1));
               pixel_valid_i = 1'b0;
               return;
            end
         end
         if ((i % IW) == IW-1 && (i / IW) >= K-1) begin
            for (int k = 0; k < WPR; k++) begin
               exp_q.push_back(expWin(off, i/IW - (K-1), k));
            end
         end
      end
      @(negedge clk_i);
      pixel_valid_i = 1'b0;
      if (npix == NPIX) begin
         checkOutput("ready_low_after_last", WB'(pixel_ready_o), WB'(0));
         checkOutput("busy_high_after_last", WB'(busy_o), WB'(1));
      end
   endtask

   task automatic waitFrames(input int target);
      for (int i = 0; i < 600 && fd_cnt < target; i++) @(negedge clk_i);
      checkOutput("frames_done", WB'(fd_cnt), WB'(target));
      @(negedge clk_i);
      checkOutput("ready_after_flush", WB'(pixel_ready_o), WB'(1));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"}, WB'(pixel_ready_o), WB'(1));
      checkOutput({tag, "_valid"}, WB'(pixel_data_valid_o), WB'(0));
      checkOutput({tag, "_done"},  WB'(frame_done_o), WB'(0));
      checkOutput({tag, "_busy"},  WB'(busy_o), WB'(0));
      checkOutput({tag, "_data"},  flatWin(), WB'(0));
   endtask

   // Output monitor: pops the scoreboard, and checks row bubbles and the frame_done timing.
   initial begin
      bit            prev_valid;
      bit            fd_pending;
      int            win_in_row;
      int            win_in_frame;
      logic [WB-1:0] exp_w;
      prev_valid = 0; fd_pending = 0; win_in_row = 0; win_in_frame = 0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            prev_valid = 0; fd_pending = 0; win_in_row = 0; win_in_frame = 0;
         end else begin
            if (frame_done_o || fd_pending) begin
               checkOutput("frame_done", WB'(frame_done_o), WB'(fd_pending));
               if (frame_done_o) begin
                  fd_cnt++;
                  checkOutput("busy_low_at_done", WB'(busy_o), WB'(0));
               end
            end
            fd_pending = 0;
            if (pixel_data_valid_o) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_win", WB'(pixel_data_valid_o), WB'(0));
               end else begin
                  exp_w = exp_q.pop_front();
                  checkOutput("win", flatWin(), exp_w);
               end
               if (win_in_row != 0) begin
                  checkOutput("row_contiguous", WB'(prev_valid), WB'(1));
               end else if (win_in_frame != 0) begin
                  checkOutput("row_bubble", WB'(prev_valid), WB'(0));
               end
               win_in_row = (win_in_row == WPR-1) ? 0 : win_in_row + 1;
               win_in_frame++;
               if (win_in_frame == WPF) begin
                  win_in_frame = 0;
                  fd_pending   = 1;
               end
            end
            prev_valid = pixel_data_valid_o;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_i         = 1'b1;
      pixel_valid_i = 1'b0;
      pixel_i       = '0;
      repeat (3) @(negedge clk_i);
      checkResetOutputs("por");
      rst_i = 1'b0;

      $display("[TB] continuous frame");
      applyStimulus(0, 1'b0, NPIX);
      waitFrames(1);

      $display("[TB] random valid gaps");
      applyStimulus(0, 1'b1, NPIX);
      waitFrames(2);

      $display("[TB] back-to-back frames");
      applyStimulus(0, 1'b0, NPIX);
      applyStimulus(100, 1'b0, NPIX);
      waitFrames(4);

      $display("[TB] async reset mid-frame");
      applyStimulus(0, 1'b0, 20);
      @(negedge clk_i);
      #2;
      checkOutput("busy_before_rst", WB'(busy_o), WB'(1));
      rst_i = 1'b1;
      #1;
      checkResetOutputs("mid_rst");
      exp_q.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      applyStimulus(0, 1'b0, NPIX);
      waitFrames(5);

      checkOutput("scoreboard_drained", WB'(exp_q.size()), WB'(0));
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
